// File: rtl/cdb_arbiter.sv
// Per-source result FIFO: registered count, full/empty from registered state.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: pushes at full are dropped (caller flags it); flush clears all state.
module cdb_fifo #(
    parameter int DW = 36,
    parameter int AW = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic [DW-1:0] i_dat,
    input  logic          i_pop,
    output logic [DW-1:0] o_dat,
    output logic          o_full,
    output logic          o_empty
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] CNT_FULL = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == CNT_FULL);
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push & ~o_full & ~i_flush;
    assign w_pop   = i_pop & ~o_empty & ~i_flush;
    assign o_dat   = r_mem[r_head];

    // Pointer and occupancy bookkeeping; flush wins over push and pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else if (i_flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage needs no reset; stale contents are never read while empty.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_tail] <= i_dat;
    end
endmodule

// Round-robin CDB arbiter draining ALU/LSB/BRU result FIFOs onto a registered bus.
// Latency: push at edge E broadcasts at the earliest after edge E+1 (no bypass).
// Backpressure: xFull per source; pushes at full are dropped and set sticky overflow.
module cdb_arbiter #(
    parameter int ROB_WIDTH  = 4,
    parameter int FIFO_WIDTH = 2
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 flushIn,
    input  logic                 aluValid,
    input  logic [ROB_WIDTH-1:0] aluRobId,
    input  logic [31:0]          aluVal,
    output logic                 aluFull,
    input  logic                 lsbValid,
    input  logic [ROB_WIDTH-1:0] lsbRobId,
    input  logic [31:0]          lsbVal,
    output logic                 lsbFull,
    input  logic                 bruValid,
    input  logic [ROB_WIDTH-1:0] bruRobId,
    input  logic [31:0]          bruVal,
    output logic                 bruFull,
    output logic                 cdbValid,
    output logic [ROB_WIDTH-1:0] cdbRobId,
    output logic [31:0]          cdbVal,
    output logic                 overflow
);
    localparam int DW = ROB_WIDTH + 32;

    logic [2:0]    w_push_req;
    logic [2:0]    w_full;
    logic [2:0]    w_empty;
    logic [3:0]    w_nonempty;
    logic [2:0]    w_pop;
    logic [DW-1:0] w_in_dat   [3];
    logic [DW-1:0] w_head_dat [3];
    logic          w_gnt_vld;
    logic [1:0]    w_gnt_idx;
    logic [DW-1:0] w_gnt_dat;

    logic                 r_cdb_vld;
    logic [ROB_WIDTH-1:0] r_cdb_rob;
    logic [31:0]          r_cdb_val;
    logic [1:0]           r_rr_ptr;
    logic                 r_ovf;

    assign w_push_req = {bruValid, lsbValid, aluValid};
    assign w_in_dat[0] = {aluRobId, aluVal};
    assign w_in_dat[1] = {lsbRobId, lsbVal};
    assign w_in_dat[2] = {bruRobId, bruVal};
    assign w_nonempty = {1'b0, ~w_empty};

    for (genvar g = 0; g < 3; g++) begin : g_src
        cdb_fifo #(.DW(DW), .AW(FIFO_WIDTH)) u_fifo (
            .i_clk   (clockIn),
            .i_rst_n (resetIn),
            .i_flush (flushIn),
            .i_push  (w_push_req[g]),
            .i_dat   (w_in_dat[g]),
            .i_pop   (w_pop[g]),
            .o_dat   (w_head_dat[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g])
        );
    end

    // Scan rrPtr, rrPtr+1, rrPtr+2 (mod 3); first non-empty source wins and is popped.
    always_comb begin : p_grant
        logic [2:0] sum;
        logic [1:0] idx;
        w_gnt_vld = 1'b0;
        w_gnt_idx = 2'd0;
        w_pop     = 3'b000;
        sum       = 3'd0;
        idx       = 2'd0;
        for (int k = 0; k < 3; k++) begin
            sum = {1'b0, r_rr_ptr} + 3'(k);
            idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (!w_gnt_vld && w_nonempty[idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = idx;
            end
        end
        if (w_gnt_vld) w_pop[w_gnt_idx] = 1'b1;
    end

    // Head data of the granted source.
    always_comb begin
        w_gnt_dat = w_head_dat[0];
        case (w_gnt_idx)
            2'd1:    w_gnt_dat = w_head_dat[1];
            2'd2:    w_gnt_dat = w_head_dat[2];
            default: w_gnt_dat = w_head_dat[0];
        endcase
    end

    // Registered broadcast and round-robin pointer; idle cycles hold the last id/value.
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            r_cdb_vld <= 1'b0;
            r_cdb_rob <= '0;
            r_cdb_val <= '0;
            r_rr_ptr  <= 2'd0;
        end else if (flushIn) begin
            r_cdb_vld <= 1'b0;
            r_rr_ptr  <= 2'd0;
        end else if (w_gnt_vld) begin
            r_cdb_vld <= 1'b1;
            r_cdb_rob <= w_gnt_dat[DW-1:32];
            r_cdb_val <= w_gnt_dat[31:0];
            r_rr_ptr  <= (w_gnt_idx == 2'd2) ? 2'd0 : w_gnt_idx + 2'd1;
        end else begin
            r_cdb_vld <= 1'b0;
        end
    end

    // Sticky overflow: any push at a full FIFO, except pushes discarded by flush.
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn)                              r_ovf <= 1'b0;
        else if (!flushIn && |(w_push_req & w_full)) r_ovf <= 1'b1;
    end

    assign aluFull  = w_full[0];
    assign lsbFull  = w_full[1];
    assign bruFull  = w_full[2];
    assign cdbValid = r_cdb_vld;
    assign cdbRobId = r_cdb_rob;
    assign cdbVal   = r_cdb_val;
    assign overflow = r_ovf;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model plus directed scenarios.
// Latency: model grants at each edge are pushed to a scoreboard, popped on cdbValid.
// Backpressure: producers obey the model's full state except the deliberate overflow push.
module tb_cdb_arbiter;
    logic        clockIn = 1'b0;
    logic        resetIn = 1'b0;
    logic        flushIn = 1'b0;
    logic        aluValid = 1'b0, lsbValid = 1'b0, bruValid = 1'b0;
    logic [3:0]  aluRobId = '0, lsbRobId = '0, bruRobId = '0;
    logic [31:0] aluVal = '0, lsbVal = '0, bruVal = '0;
    logic        aluFull, lsbFull, bruFull, cdbValid, overflow;
    logic [3:0]  cdbRobId;
    logic [31:0] cdbVal;

    cdb_arbiter #(.ROB_WIDTH(4), .FIFO_WIDTH(2)) dut (
        .clockIn(clockIn), .resetIn(resetIn), .flushIn(flushIn),
        .aluValid(aluValid), .aluRobId(aluRobId), .aluVal(aluVal), .aluFull(aluFull),
        .lsbValid(lsbValid), .lsbRobId(lsbRobId), .lsbVal(lsbVal), .lsbFull(lsbFull),
        .bruValid(bruValid), .bruRobId(bruRobId), .bruVal(bruVal), .bruFull(bruFull),
        .cdbValid(cdbValid), .cdbRobId(cdbRobId), .cdbVal(cdbVal), .overflow(overflow)
    );

    always #5 clockIn = ~clockIn;

    int n_cmp = 0;
    int n_bad = 0;
    logic [35:0] q0[$], q1[$], q2[$], sb[$];
    int rr_m = 0;
    bit ovf_m = 1'b0;
    bit exp_vld = 1'b0;
    bit mon_en = 1'b0;

    // Reference model of one clock edge, evaluated on the inputs the DUT samples.
    task automatic model_edge();
        int sz[3];
        int w;
        sz[0] = q0.size(); sz[1] = q1.size(); sz[2] = q2.size();
        w = 0;
        if (flushIn) begin
            q0.delete(); q1.delete(); q2.delete();
            rr_m = 0;
            exp_vld = 1'b0;
        end else begin
            exp_vld = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (!exp_vld && sz[(rr_m + k) % 3] > 0) begin
                    exp_vld = 1'b1;
                    w = (rr_m + k) % 3;
                end
            end
            if (exp_vld) begin
                case (w)
                    0: sb.push_back(q0.pop_front());
                    1: sb.push_back(q1.pop_front());
                    default: sb.push_back(q2.pop_front());
                endcase
                rr_m = (w == 2) ? 0 : w + 1;
            end
            if (aluValid) begin if (sz[0] == 4) ovf_m = 1'b1; else q0.push_back({aluRobId, aluVal}); end
            if (lsbValid) begin if (sz[1] == 4) ovf_m = 1'b1; else q1.push_back({lsbRobId, lsbVal}); end
            if (bruValid) begin if (sz[2] == 4) ovf_m = 1'b1; else q2.push_back({bruRobId, bruVal}); end
        end
    endtask

    // One clock: inputs already driven by the caller are sampled, model advances, inputs cleared.
    task automatic tick();
        @(posedge clockIn);
        model_edge();
        #1;
        aluValid = 1'b0; lsbValid = 1'b0; bruValid = 1'b0; flushIn = 1'b0;
    endtask

    // Scoreboard monitor: compares broadcasts, full flags and overflow against the model.
    always @(negedge clockIn) begin
        if (mon_en) begin
            logic [35:0] e;
            n_cmp++;
            if (cdbValid !== exp_vld) begin
                n_bad++;
                $display("FAIL sb_valid t=%0t got %b expected %b", $time, cdbValid, exp_vld);
            end
            if (cdbValid === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_spurious t=%0t got id=%0d val=%h expected no broadcast", $time, cdbRobId, cdbVal);
                end else begin
                    e = sb.pop_front();
                    if ({cdbRobId, cdbVal} !== e) begin
                        n_bad++;
                        $display("FAIL sb_data t=%0t got id=%0d val=%h expected id=%0d val=%h",
                                 $time, cdbRobId, cdbVal, e[35:32], e[31:0]);
                    end
                end
            end
            n_cmp++;
            if ({bruFull, lsbFull, aluFull} !== {q2.size() == 4, q1.size() == 4, q0.size() == 4}) begin
                n_bad++;
                $display("FAIL sb_full t=%0t got %b expected %b", $time, {bruFull, lsbFull, aluFull},
                         {q2.size() == 4, q1.size() == 4, q0.size() == 4});
            end
            n_cmp++;
            if (overflow !== ovf_m) begin
                n_bad++;
                $display("FAIL sb_overflow t=%0t got %b expected %b", $time, overflow, ovf_m);
            end
        end
    end

    task automatic test_reset();
        resetIn = 1'b0;
        #12;
        n_cmp++;
        if ({cdbValid, cdbRobId, cdbVal} !== 37'd0) begin
            n_bad++;
            $display("FAIL reset_cdb got v=%b id=%0d val=%h expected all 0", cdbValid, cdbRobId, cdbVal);
        end
        n_cmp++;
        if ({aluFull, lsbFull, bruFull, overflow} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags got %b expected 0000", {aluFull, lsbFull, bruFull, overflow});
        end
        @(negedge clockIn);
        resetIn = 1'b1;
        #1;
        mon_en = 1'b1;
        @(posedge clockIn);
        #1;
    endtask

    task automatic test_single();
        aluValid = 1'b1; aluRobId = 4'd3; aluVal = 32'h11;
        tick();
        n_cmp++;
        if (cdbValid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_nobypass got %b expected 0", cdbValid);
        end
        tick();
        n_cmp++;
        if ({cdbValid, cdbRobId, cdbVal} !== {1'b1, 4'd3, 32'h11}) begin
            n_bad++;
            $display("FAIL single_bcast got v=%b id=%0d val=%h expected v=1 id=3 val=11", cdbValid, cdbRobId, cdbVal);
        end
        tick();
        n_cmp++;
        if (cdbValid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_oneshot got %b expected 0", cdbValid);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_id [4];
        exp_id[0] = 4'd1; exp_id[1] = 4'd2; exp_id[2] = 4'd5; exp_id[3] = 4'd6;
        flushIn = 1'b1;
        tick();
        aluValid = 1'b1; aluRobId = 4'd1; aluVal = 32'hA1;
        lsbValid = 1'b1; lsbRobId = 4'd2; lsbVal = 32'hB2;
        bruValid = 1'b1; bruRobId = 4'd5; bruVal = 32'hC5;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (cdbValid !== 1'b1 || cdbRobId !== exp_id[i]) begin
                n_bad++;
                $display("FAIL rr_order%0d got v=%b id=%0d expected v=1 id=%0d", i, cdbValid, cdbRobId, exp_id[i]);
            end
        end
        // Pointer must have wrapped to the ALU: a fresh triple starts with the ALU again.
        aluValid = 1'b1; aluRobId = 4'd6; aluVal = 32'hA6;
        lsbValid = 1'b1; lsbRobId = 4'd7; lsbVal = 32'hB7;
        bruValid = 1'b1; bruRobId = 4'd8; bruVal = 32'hC8;
        tick();
        tick();
        n_cmp++;
        if (cdbValid !== 1'b1 || cdbRobId !== exp_id[3]) begin
            n_bad++;
            $display("FAIL rr_wrap got v=%b id=%0d expected v=1 id=6", cdbValid, cdbRobId);
        end
        repeat (4) tick();
    endtask

    task automatic test_flush();
        for (int c = 0; c < 2; c++) begin
            aluValid = 1'b1; aluRobId = 4'(c);     aluVal = 32'hF000 + 32'(c);
            lsbValid = 1'b1; lsbRobId = 4'(c + 4); lsbVal = 32'hF100 + 32'(c);
            bruValid = 1'b1; bruRobId = 4'(c + 8); bruVal = 32'hF200 + 32'(c);
            tick();
        end
        flushIn = 1'b1;
        bruValid = 1'b1; bruRobId = 4'd9; bruVal = 32'hBAD9;
        tick();
        n_cmp++;
        if ({cdbValid, aluFull, lsbFull, bruFull} !== 4'b0000) begin
            n_bad++;
            $display("FAIL flush_clear got v/full=%b expected 0000", {cdbValid, aluFull, lsbFull, bruFull});
        end
        tick();
        n_cmp++;
        if (cdbValid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_drop got %b expected 0", cdbValid);
        end
        aluValid = 1'b1; aluRobId = 4'd7; aluVal = 32'h77;
        tick();
        tick();
        n_cmp++;
        if ({cdbValid, cdbRobId, cdbVal} !== {1'b1, 4'd7, 32'h77}) begin
            n_bad++;
            $display("FAIL flush_after got v=%b id=%0d val=%h expected v=1 id=7 val=77", cdbValid, cdbRobId, cdbVal);
        end
        tick();
        n_cmp++;
        if (cdbValid !== 1'b0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_alone got v=%b ovf=%b expected v=0 ovf=0", cdbValid, overflow);
        end
    endtask

    task automatic test_fill_overflow();
        bit saw_full;
        bit done;
        saw_full = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (q0.size() < 4) begin aluValid = 1'b1; aluRobId = 4'(c); aluVal = 32'hA000 + 32'(c); end
            if (q1.size() < 4) begin lsbValid = 1'b1; lsbRobId = 4'(c); lsbVal = 32'hB000 + 32'(c); end
            if (q2.size() < 4) begin bruValid = 1'b1; bruRobId = 4'(c); bruVal = 32'hC000 + 32'(c); end
            tick();
            if (lsbFull === 1'b1) saw_full = 1'b1;
        end
        n_cmp++;
        if (saw_full !== 1'b1 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_full got saw_lsbFull=%b ovf=%b expected 1 0", saw_full, overflow);
        end
        for (int c = 0; c < 6 && !done; c++) begin
            lsbValid = 1'b1;
            if (q1.size() == 4) begin
                lsbRobId = 4'd15; lsbVal = 32'hDEAD;
                done = 1'b1;
            end else begin
                lsbRobId = 4'd14; lsbVal = 32'hB100 + 32'(c);
            end
            tick();
        end
        n_cmp++;
        if (done !== 1'b1 || overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_set got pushed=%b ovf=%b expected 1 1", done, overflow);
        end
        repeat (16) tick();
        n_cmp++;
        if (overflow !== 1'b1 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL ovf_sticky got ovf=%b pending=%0d expected 1 0", overflow, sb.size());
        end
    endtask

    task automatic test_async_reset();
        aluValid = 1'b1; aluRobId = 4'd2; aluVal = 32'h2222;
        lsbValid = 1'b1; lsbRobId = 4'd4; lsbVal = 32'h4444;
        tick();
        bruValid = 1'b1; bruRobId = 4'd6; bruVal = 32'h6666;
        tick();
        n_cmp++;
        if (cdbValid !== 1'b1) begin
            n_bad++;
            $display("FAIL areset_pre got %b expected 1", cdbValid);
        end
        #2;
        mon_en = 1'b0;
        resetIn = 1'b0;
        #1;
        n_cmp++;
        if ({cdbValid, cdbRobId, cdbVal, overflow, aluFull, lsbFull, bruFull} !== 41'd0) begin
            n_bad++;
            $display("FAIL areset_async got v=%b id=%0d val=%h ovf=%b expected all 0", cdbValid, cdbRobId, cdbVal, overflow);
        end
        q0.delete(); q1.delete(); q2.delete(); sb.delete();
        rr_m = 0; ovf_m = 1'b0; exp_vld = 1'b0;
        @(negedge clockIn);
        @(negedge clockIn);
        resetIn = 1'b1;
        #1;
        mon_en = 1'b1;
        @(posedge clockIn);
        #1;
        repeat (4) tick();
        lsbValid = 1'b1; lsbRobId = 4'd12; lsbVal = 32'hC0DE;
        tick();
        tick();
        n_cmp++;
        if ({cdbValid, cdbRobId, cdbVal} !== {1'b1, 4'd12, 32'hC0DE}) begin
            n_bad++;
            $display("FAIL areset_after got v=%b id=%0d val=%h expected v=1 id=12 val=c0de", cdbValid, cdbRobId, cdbVal);
        end
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_flush();
        test_fill_overflow();
        test_async_reset();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover got %0d pending expected 0", sb.size());
        end
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
